// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types and constants.
// Write-back select codes, load funct3 values and WB FSM states.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension.
// Picks the addressed byte/half from an aligned word.
module load_extend
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte and half-word, then extend by funct3.
    always_comb begin
        byte_sel = rdata[8*off +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        unique case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  value = {24'd0, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  value = {16'd0, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects result and drives the register-file port.
// Stalls upstream while a load waits for late memory data.
module wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              RegWrite_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic [1:0]        MemToReg_i,
    input  logic [2:0]        Funct3_i,
    input  logic [XLEN-1:0]   ALUResult_i,
    input  logic [XLEN-1:0]   PCplus4_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              stall_o,
    output logic              RegWrite_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic [XLEN-1:0]   RDdata_o,
    output logic              proto_err_o
);

    import riscv_pkg::*;

    wb_state_e         state_q, state_d;
    logic              rw_q, rw_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              perr_q, perr_d;

    logic [REG_AW-1:0] cap_rd_q, cap_rd_d;
    logic              cap_wr_q, cap_wr_d;
    logic [2:0]        cap_f3_q, cap_f3_d;
    logic [1:0]        cap_off_q, cap_off_d;

    logic              accept;
    logic              wr;
    logic              is_load;
    logic [2:0]        ext_f3;
    logic [1:0]        ext_off;
    logic [31:0]       ext_val;

    assign accept  = valid_i & ~flush_i & (state_q == IDLE);
    assign wr      = RegWrite_i & (RDaddr_i != '0);
    assign is_load = (MemToReg_i == WB_MEM);

    // A waiting load extends with its captured size/offset.
    assign ext_f3  = (state_q == WAIT_LOAD) ? cap_f3_q  : Funct3_i;
    assign ext_off = (state_q == WAIT_LOAD) ? cap_off_q : ALUResult_i[1:0];

    load_extend u_ext (
        .funct3 (ext_f3),
        .off    (ext_off),
        .rdata  (mem_rdata_i[31:0]),
        .value  (ext_val)
    );

    // Next-state, result selection and load capture.
    always_comb begin
        state_d   = state_q;
        rw_d      = 1'b0;
        rd_d      = rd_q;
        data_d    = data_q;
        perr_d    = perr_q;
        cap_rd_d  = cap_rd_q;
        cap_wr_d  = cap_wr_q;
        cap_f3_d  = cap_f3_q;
        cap_off_d = cap_off_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_load && !mem_rvalid_i) begin
                        cap_rd_d  = RDaddr_i;
                        cap_wr_d  = wr;
                        cap_f3_d  = Funct3_i;
                        cap_off_d = ALUResult_i[1:0];
                        state_d   = WAIT_LOAD;
                    end else begin
                        rw_d = wr;
                        rd_d = RDaddr_i;
                        if (is_load)
                            data_d = ext_val;
                        else if (MemToReg_i == WB_PC4)
                            data_d = PCplus4_i;
                        else
                            data_d = ALUResult_i;
                    end
                end
                if (mem_rvalid_i && !(accept && is_load))
                    perr_d = 1'b1;
            end
            WAIT_LOAD: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    rw_d    = cap_wr_q;
                    rd_d    = cap_rd_q;
                    data_d  = ext_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any pending load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            cap_rd_q  <= '0;
            cap_wr_q  <= 1'b0;
            cap_f3_q  <= '0;
            cap_off_q <= '0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            cap_rd_q  <= cap_rd_d;
            cap_wr_q  <= cap_wr_d;
            cap_f3_q  <= cap_f3_d;
            cap_off_q <= cap_off_d;
        end
    end

    assign stall_o     = (state_q == WAIT_LOAD);
    assign RegWrite_o  = rw_q;
    assign RDaddr_o    = rd_q;
    assign RDdata_o    = data_q;
    assign proto_err_o = perr_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the RISC-V pipeline and the producer side of the register-file write port.
- Registers MEM-stage results and selects the write value (ALU result, aligned load data or PC+4).
- Tolerates data memory returning load data late by stalling the pipeline.
- Drives RDaddr/RDdata/RegWrite into the register file, which writes on negedge clk. A value therefore becomes readable in the same cycle it is presented.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  MEM stage holds a valid instruction this cycle.
- flush_i  in  1  kill the instruction presented this cycle.
- RegWrite_i  in  1  instruction writes rd.
- RDaddr_i  in  5  destination register.
- MemToReg_i  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- Funct3_i  in  3  load size/sign.
- ALUResult_i  in  32  ALU result; also the load address.
- PCplus4_i  in  32  link value.
- mem_rvalid_i  in  1  load data valid.
- mem_rdata_i  in  32  raw aligned memory word.
- stall_o  out  1  hold IF..MEM stages.
- RegWrite_o  out  1  register-file write enable.
- RDaddr_o  out  5  register-file write address.
- RDdata_o  out  32  register-file write data.
- proto_err_o  out  1  sticky: mem_rvalid_i seen with no pending load.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - RegWrite_o = 0, RDaddr_o = 0, RDdata_o = 0, stall_o = 0, proto_err_o = 0.
  - Reset asserted in WAIT_LOAD abandons the pending load; no write occurs.
- Accept condition: accept = valid_i & ~flush_i & (state == IDLE).
- Write qualification: wr = RegWrite_i & (RDaddr_i != 0). A write to x0 never asserts RegWrite_o.
- States: IDLE, WAIT_LOAD.
- IDLE, accept, MemToReg != 01:
  - Next posedge: RDaddr_o = RDaddr_i, RegWrite_o = wr.
  - RDdata_o = ALUResult_i, or PCplus4_i when MemToReg = 10.
  - Latency is 1 cycle. RegWrite_o is high for exactly one cycle per instruction.
- IDLE, accept, load, mem_rvalid_i = 1 in the same cycle:
  - Same as above, with RDdata_o = extend(mem_rdata_i).
- IDLE, accept, load, mem_rvalid_i = 0:
  - Capture rd, wr, Funct3_i and ALUResult_i[1:0].
  - Go to WAIT_LOAD. RegWrite_o = 0 next cycle.
- WAIT_LOAD:
  - stall_o = 1 (registered; high from the cycle after the load is accepted).
  - valid_i and flush_i are ignored; upstream is held.
  - The pending load is older than any flush source, so it always completes.
  - On mem_rvalid_i = 1: next posedge go to IDLE, stall_o = 0, and perform the write with the captured rd/wr and extend(mem_rdata_i).
- No accept (bubble, flush, or not valid): next posedge RegWrite_o = 0. RDaddr_o and RDdata_o hold their previous values.
- extend(), using byte offset off = ALUResult[1:0]:
  - 000 LB: sign-extend byte[off].
  - 100 LBU: zero-extend byte[off].
  - 001 LH: sign-extend half[off[1]].
  - 101 LHU: zero-extend half[off[1]].
  - 010 LW and all other codes: full word.
- Protocol error: mem_rvalid_i = 1 while in IDLE without a load being accepted that cycle sets proto_err_o. It is cleared only by reset. The data is discarded.
- No back-to-back load overlap: at most one outstanding load.

Decomposition:
- Shared package riscv_pkg holds:
  - wb_sel_e enum: WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - wb_state_e: IDLE, WAIT_LOAD.
  - XLEN constant.
- One combinational sub-module, load_extend (inputs: funct3, off, rdata; output: 32-bit value). It is reused by a future forwarding path.

Test Plan:
- ALU write: valid_i = 1, RegWrite_i = 1, RDaddr_i = 5, MemToReg = 00, ALUResult_i = 0x1234_5678 → next cycle RegWrite_o = 1, RDaddr_o = 5, RDdata_o = 0x1234_5678; following cycle RegWrite_o = 0.
- x0 suppression and JAL: RDaddr_i = 0 → RegWrite_o stays 0. Then RDaddr_i = 1, MemToReg = 10, PCplus4_i = 0x104 → RDdata_o = 0x104.
- Load extension, mem_rdata_i = 0x80FF_7F01, rvalid in the same cycle:
  - LB off = 3 → 0xFFFF_FF80.
  - LBU off = 2 → 0x0000_00FF.
  - LH off = 2 → 0xFFFF_80FF.
  - LHU off = 0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- Late load: load to rd = 7 with rvalid 3 cycles later → stall_o high for 3 cycles, no write during the wait, write of x7 the cycle after rvalid. flush_i and valid_i pulses during the wait have no effect.
- Flush and protocol: flush_i = 1 with valid_i = 1 → no write. mem_rvalid_i pulse in IDLE with no load → proto_err_o = 1 and sticky.
- Reset mid-WAIT_LOAD: drop rst_n asynchronously between clock edges → all outputs 0 immediately. A later rvalid causes no write and sets proto_err_o.
